// File: rtl/mux_gate_checker.sv
// Checker stage behind the 2:1-mux gate block: a two-stage capture/compare pipeline
// accumulating pass/fail counts, a sticky per-gate error mask and {x,y} coverage over a run.
module mux_gate_checker #(
    parameter int CNT_W       = 8,
    parameter int NUM_VECTORS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             x,
    input  logic             y,
    input  logic             and_i,
    input  logic             nand_i,
    input  logic             or_i,
    input  logic             nor_i,
    input  logic             na_x_i,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [4:0]       fail_mask,
    output logic [3:0]       cov,
    output logic [1:0]       err_xy,
    output logic             err_valid
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           r_state;
    logic [CNT_W-1:0] r_acc_cnt;
    logic             r_s1_valid;
    logic             r_s1_x;
    logic             r_s1_y;
    logic [4:0]       r_s1_out;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic [4:0]       r_fail_mask;
    logic [3:0]       r_cov;
    logic [1:0]       r_err_xy;
    logic             r_err_valid;
    logic             r_busy;
    logic             r_done;

    logic [4:0]       w_exp;
    logic [4:0]       w_err;

    // Bit order {na_x, nor, or, nand, and}, matching fail_mask.
    assign w_exp = {~r_s1_x, ~(r_s1_x | r_s1_y), r_s1_x | r_s1_y,
                    ~(r_s1_x & r_s1_y), r_s1_x & r_s1_y};
    assign w_err = r_s1_out ^ w_exp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc_cnt   <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_x      <= 1'b0;
            r_s1_y      <= 1'b0;
            r_s1_out    <= '0;
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_fail_mask <= '0;
            r_cov       <= '0;
            r_err_xy    <= '0;
            r_err_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // Stage 2: score the sample captured on the previous edge.
            if (r_s1_valid) begin
                if (w_err == 5'd0) begin
                    if (r_pass_cnt != CNT_MAX)
                        r_pass_cnt <= r_pass_cnt + 1'b1;
                end else begin
                    if (r_fail_cnt != CNT_MAX)
                        r_fail_cnt <= r_fail_cnt + 1'b1;
                    if (!r_err_valid) begin
                        r_err_xy    <= {r_s1_x, r_s1_y};
                        r_err_valid <= 1'b1;
                    end
                end
                r_fail_mask <= r_fail_mask | w_err;
                r_cov[{r_s1_x, r_s1_y}] <= 1'b1;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    r_s1_valid <= 1'b0;
                    if (start) begin
                        r_state     <= S_RUN;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_acc_cnt   <= '0;
                        r_pass_cnt  <= '0;
                        r_fail_cnt  <= '0;
                        r_fail_mask <= '0;
                        r_cov       <= '0;
                        r_err_xy    <= '0;
                        r_err_valid <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_s1_valid <= in_valid;
                    if (in_valid) begin
                        r_s1_x    <= x;
                        r_s1_y    <= y;
                        r_s1_out  <= {na_x_i, nor_i, or_i, nand_i, and_i};
                        r_acc_cnt <= r_acc_cnt + 1'b1;
                        if (r_acc_cnt == LAST_IDX)
                            r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_s1_valid <= 1'b0;
                    r_state    <= S_DONE;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b1;
                end
                default: begin
                    r_s1_valid <= 1'b0;
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign pass_cnt  = r_pass_cnt;
    assign fail_cnt  = r_fail_cnt;
    assign fail_mask = r_fail_mask;
    assign cov       = r_cov;
    assign err_xy    = r_err_xy;
    assign err_valid = r_err_valid;

endmodule

// File: tb/tb_mux_gate_checker.sv
// Bench for mux_gate_checker: table-driven runs, randomized runs against a run-level
// reference model, plus hand sequences for reset, mid-run reset and restart.
module tb_mux_gate_checker;

    localparam int NV = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, in_valid, x, y, and_i, nand_i, or_i, nor_i, na_x_i;
    logic busy, done, err_valid;
    logic [7:0] pass_cnt, fail_cnt;
    logic [4:0] fail_mask;
    logic [3:0] cov;
    logic [1:0] err_xy;

    logic start_b, in_valid_b, busy_b, done_b, err_valid_b;
    logic [1:0] pass_b, fail_b, err_xy_b;
    logic [4:0] fail_mask_b;
    logic [3:0] cov_b;

    mux_gate_checker #(.CNT_W(8), .NUM_VECTORS(NV)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .x(x), .y(y),
        .and_i(and_i), .nand_i(nand_i), .or_i(or_i), .nor_i(nor_i), .na_x_i(na_x_i),
        .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .fail_mask(fail_mask), .cov(cov), .err_xy(err_xy), .err_valid(err_valid)
    );

    mux_gate_checker #(.CNT_W(2), .NUM_VECTORS(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid_b), .x(x), .y(y),
        .and_i(and_i), .nand_i(nand_i), .or_i(or_i), .nor_i(nor_i), .na_x_i(na_x_i),
        .busy(busy_b), .done(done_b), .pass_cnt(pass_b), .fail_cnt(fail_b),
        .fail_mask(fail_mask_b), .cov(cov_b), .err_xy(err_xy_b), .err_valid(err_valid_b)
    );

    typedef struct {
        logic [7:0]  xyv;
        logic [19:0] flip;
        logic [15:0] vpat;
        logic        noise;
        logic [7:0]  e_pass;
        logic [7:0]  e_fail;
        logic [4:0]  e_mask;
        logic [3:0]  e_cov;
        logic [1:0]  e_xy;
        logic        e_ev;
    } vec_t;

    vec_t tbl [5];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference gate functions from plain arithmetic on 0/1 values.
    function automatic logic [4:0] ref_out(input logic xi, input logic yi);
        int a, b;
        a = int'(xi);
        b = int'(yi);
        ref_out[0] = (a * b == 1);
        ref_out[1] = (a * b == 0);
        ref_out[2] = (a + b > 0);
        ref_out[3] = (a + b == 0);
        ref_out[4] = (a == 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] xy, input logic [4:0] outs);
        in_valid = v;
        x = xy[1];
        y = xy[0];
        {na_x_i, nor_i, or_i, nand_i, and_i} = outs;
    endtask

    task automatic do_run(input logic [7:0] xyv, input logic [19:0] outv,
                          input logic [15:0] vpat, input logic noise);
        int ep, ef, k, cyc;
        logic [4:0] em, r, o;
        logic [3:0] ec;
        logic [1:0] ex, s;
        logic ev, v;
        ep = 0; ef = 0; em = '0; ec = '0; ex = '0; ev = 1'b0;
        for (int i = 0; i < NV; i++) begin
            s = xyv[2*i +: 2];
            o = outv[5*i +: 5];
            r = ref_out(s[1], s[0]);
            if (o == r) ep++;
            else begin
                ef++;
                if (!ev) begin ev = 1'b1; ex = s; end
            end
            for (int b = 0; b < 5; b++) if (o[b] != r[b]) em[b] = 1'b1;
            ec[s] = 1'b1;
        end
        // Start edge carries a wrong sample that must not be accepted.
        start = 1'b1;
        drive(1'b1, 2'b01, 5'b11111);
        tick();
        check("start_clear", {busy, done, pass_cnt, fail_cnt, fail_mask, cov, err_xy, err_valid},
              {1'b1, 29'd0});
        start = 1'b0;
        k = 0;
        cyc = 0;
        while (k < NV && cyc < 40) begin
            v = (cyc < 16) ? vpat[cyc] : 1'b1;
            if (v) drive(1'b1, xyv[2*k +: 2], outv[5*k +: 5]);
            else drive(1'b0, 2'b10, 5'b11111);
            if (noise) start = ($urandom_range(0, 2) == 0);
            tick();
            check("pipe_total", 32'(pass_cnt) + 32'(fail_cnt), k);
            check("busy_run", {busy, done}, 2'b10);
            if (v) k++;
            cyc++;
        end
        if (k < NV) check("accept_timeout", k, NV);
        start = noise;
        drive(1'b1, 2'($urandom), 5'($urandom));
        tick();
        check("done_timing", {busy, done}, 2'b01);
        start = 1'b0;
        drive(1'b1, 2'($urandom), 5'($urandom));
        tick();
        in_valid = 1'b0;
        check("hold_done", {busy, done}, 2'b01);
        check("m_pass", pass_cnt, ep);
        check("m_fail", fail_cnt, ef);
        check("m_mask", fail_mask, em);
        check("m_cov", cov, ec);
        check("m_err_xy", err_xy, ex);
        check("m_err_valid", err_valid, ev);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [19:0] outv;
        logic [7:0]  xyv;
        logic [19:0] flip;
        logic [1:0]  s;

        tbl[0] = '{8'b11_01_10_00, 20'd0, 16'hFFFF, 1'b0, 8'd4, 8'd0, 5'b00000, 4'b1111, 2'b00, 1'b0};
        tbl[1] = '{8'b11_01_10_00, 20'b10000_00000_00000_01000, 16'hFFFF, 1'b0,
                   8'd2, 8'd2, 5'b11000, 4'b1111, 2'b00, 1'b1};
        tbl[2] = '{8'b11_11_11_11, 20'b00001_00000_00001_00000, 16'hFFFF, 1'b0,
                   8'd2, 8'd2, 5'b00001, 4'b1000, 2'b11, 1'b1};
        tbl[3] = '{8'b00_10_01_01, 20'b00000_00001_00110_00000, 16'hFFFF, 1'b0,
                   8'd2, 8'd2, 5'b00111, 4'b0111, 2'b01, 1'b1};
        tbl[4] = '{8'b11_11_00_00, 20'd0, 16'hFFD9, 1'b1, 8'd4, 8'd0, 5'b00000, 4'b1001, 2'b00, 1'b0};

        // Reset with random inputs, then valid pulses without start.
        rst = 1'b1; start = 1'b1; start_b = 1'b0; in_valid_b = 1'b0;
        drive(1'b1, 2'($urandom), 5'($urandom));
        tick();
        drive(1'b1, 2'($urandom), 5'($urandom));
        tick();
        check("reset_state", {busy, done, pass_cnt, fail_cnt, fail_mask, cov, err_xy, err_valid}, 0);
        rst = 1'b0; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'($urandom), 5'($urandom));
            tick();
            check("idle_valid", {busy, done, pass_cnt, fail_cnt, cov, err_valid}, 0);
        end
        in_valid = 1'b0;

        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < NV; i++) begin
                s = tbl[t].xyv[2*i +: 2];
                outv[5*i +: 5] = ref_out(s[1], s[0]) ^ tbl[t].flip[5*i +: 5];
            end
            do_run(tbl[t].xyv, outv, tbl[t].vpat, tbl[t].noise);
            check("t_pass", pass_cnt, tbl[t].e_pass);
            check("t_fail", fail_cnt, tbl[t].e_fail);
            check("t_mask", fail_mask, tbl[t].e_mask);
            check("t_cov", cov, tbl[t].e_cov);
            check("t_err_xy", err_xy, tbl[t].e_xy);
            check("t_err_valid", err_valid, tbl[t].e_ev);
        end

        // Mid-run reset after two faulty samples.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 2'(i), ~ref_out(1'b0, 1'(i)));
            tick();
        end
        rst = 1'b1;
        drive(1'b1, 2'b11, 5'b00000);
        tick();
        check("midrun_rst", {busy, done, pass_cnt, fail_cnt, fail_mask, cov, err_xy, err_valid}, 0);
        rst = 1'b0;
        tick();
        check("post_rst_idle", {busy, done, pass_cnt, fail_cnt, fail_mask, cov, err_valid}, 0);
        for (int i = 0; i < NV; i++) begin
            s = tbl[0].xyv[2*i +: 2];
            outv[5*i +: 5] = ref_out(s[1], s[0]);
        end
        do_run(tbl[0].xyv, outv, 16'hFFFF, 1'b0);
        check("clean_pass", pass_cnt, 8'd4);
        check("clean_mask", fail_mask, 5'd0);

        // Randomized runs.
        for (int r = 0; r < 20; r++) begin
            xyv = 8'($urandom);
            flip = '0;
            for (int i = 0; i < NV; i++)
                if ($urandom_range(0, 2) == 0) flip[5*i +: 5] = 5'($urandom_range(1, 31));
            for (int i = 0; i < NV; i++) begin
                s = xyv[2*i +: 2];
                outv[5*i +: 5] = ref_out(s[1], s[0]) ^ flip[5*i +: 5];
            end
            do_run(xyv, outv, 16'($urandom), 1'b1);
        end

        // Small instance: CNT_W=2, NUM_VECTORS=3; start while busy is ignored.
        start_b = 1'b1;
        tick();
        check("b_start", {busy_b, done_b}, 2'b10);
        start_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s = 2'($urandom);
            x = s[1]; y = s[0];
            {na_x_i, nor_i, or_i, nand_i, and_i} = ref_out(s[1], s[0]);
            in_valid_b = 1'b1;
            start_b = (i == 1);
            tick();
        end
        in_valid_b = 1'b0; start_b = 1'b0;
        tick();
        check("b_done", {busy_b, done_b}, 2'b01);
        check("b_pass", pass_b, 2'd3);
        check("b_fail", fail_b, 2'd0);
        start_b = 1'b1;
        tick();
        check("b_restart_clear", {busy_b, done_b, pass_b, fail_b, fail_mask_b, err_valid_b, cov_b},
              16'h8000);
        start_b = 1'b0;
        for (int i = 1; i < 4; i++) begin
            s = 2'(i);
            x = s[1]; y = s[0];
            {na_x_i, nor_i, or_i, nand_i, and_i} = ~ref_out(s[1], s[0]);
            in_valid_b = 1'b1;
            tick();
        end
        in_valid_b = 1'b0;
        tick();
        check("b_fail_all", {pass_b, fail_b}, 4'b0011);
        check("b_mask", fail_mask_b, 5'b11111);
        check("b_err", {err_xy_b, err_valid_b}, 3'b011);
        check("b_cov", cov_b, 4'b1110);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
